bias_sweep_sequencer: RTL and testbench



---
 rtl/bias_sweep_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_bias_sweep_sequencer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_sweep_sequencer.sv
//------------------------------------------------------------------------------
// bias_sweep_sequencer
//   DC bias-sweep controller: steps NCH DAC codes per point, settles, averages
//   2^AVG_LOG2 ADC samples per probe and streams one result per point.
//   Optional feature macro: SWEEP_BIDIR_EN (adds reverse leg and sweep_dir).
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module bias_sweep_sequencer #(
  parameter int NCH      = 2,
  parameter int DW       = 12,
  parameter int NPROBE   = 2,
  parameter int AW       = 12,
  parameter int AVG_LOG2 = 2,
  parameter int SETTLE_W = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [NCH*DW-1:0]                cfg_start,
  input  logic [NCH*DW-1:0]                cfg_step,
  input  logic [15:0]                      cfg_npts,
  input  logic [SETTLE_W-1:0]              cfg_settle,
  output logic                             busy,
  output logic                             done,
  output logic [NCH*DW-1:0]                dac_code,
  output logic                             dac_load,
  input  logic                             adc_valid,
  input  logic [NPROBE*AW-1:0]             adc_data,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [15:0]                      res_index,
  output logic [NPROBE*(AW+AVG_LOG2)-1:0]  res_data
`ifdef SWEEP_BIDIR_EN
  ,
  output logic                             sweep_dir
`endif
);

  // Position width covers start + 65535 * max |step| without overflow.
  localparam int c_pw   = DW + 18;
  localparam int c_accw = AW + AVG_LOG2;
  localparam int c_sw   = AVG_LOG2 + 1;
  localparam logic [c_sw-1:0] c_nsamp_m1 = c_sw'((1 << AVG_LOG2) - 1);
  localparam logic signed [c_pw-1:0] c_max = {{(c_pw-DW){1'b0}}, {DW{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_ACQ    = 3'd3,
    S_EMIT   = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  state_t r_state, w_state_next;

  logic [NCH*DW-1:0]       r_step;
  logic [15:0]             r_npts_m1;
  logic [SETTLE_W-1:0]     r_settle;
  logic [SETTLE_W-1:0]     r_cnt;
  logic [c_sw-1:0]         r_scnt;
  logic [15:0]             r_idx;
  logic [15:0]             r_res_idx;
  logic                    r_dir;
  logic [NCH*DW-1:0]       r_dac;
  logic signed [c_pw-1:0]  r_pos [NCH];
  logic [c_accw-1:0]       r_acc [NPROBE];

  logic                    w_last;
  logic                    w_turn;
  logic                    w_dir_next;
  logic                    w_xfer;
  logic [15:0]             w_idx_next;
  logic signed [c_pw-1:0]  w_step     [NCH];
  logic signed [c_pw-1:0]  w_pos_next [NCH];
  logic [NCH*DW-1:0]       w_sat_next;

  function automatic logic [DW-1:0] f_sat(input logic signed [c_pw-1:0] v);
    if (v < 0)
      return '0;
    else if (v > c_max)
      return {DW{1'b1}};
    else
      return v[DW-1:0];
  endfunction

  // Unsaturated position is carried so reverse-leg points reproduce forward codes.
  generate
    for (genvar c = 0; c < NCH; c++) begin : g_ch
      assign w_step[c]     = {{(c_pw-DW){r_step[c*DW+DW-1]}}, r_step[c*DW +: DW]};
      assign w_pos_next[c] = w_dir_next ? (r_pos[c] - w_step[c]) : (r_pos[c] + w_step[c]);
      assign w_sat_next[c*DW +: DW] = f_sat(w_pos_next[c]);
    end
    for (genvar p = 0; p < NPROBE; p++) begin : g_pr
      assign res_data[p*c_accw +: c_accw] = r_acc[p];
    end
  endgenerate

  assign w_xfer     = (r_state == S_EMIT) && res_ready;
  assign w_dir_next = r_dir | w_turn;
  assign w_idx_next = w_dir_next ? (r_idx - 16'd1) : (r_idx + 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_last       = 1'b0;
    w_turn       = 1'b0;
`ifdef SWEEP_BIDIR_EN
    if (!r_dir) begin
      w_last = (r_idx == r_npts_m1) && (r_npts_m1 == 16'd0);
      w_turn = (r_idx == r_npts_m1) && (r_npts_m1 != 16'd0);
    end else begin
      w_last = (r_idx == 16'd0);
    end
`else
    w_last = (r_idx == r_npts_m1);
`endif
    case (r_state)
      S_IDLE:   if (start) w_state_next = S_LOAD;
      S_LOAD:   w_state_next = (r_settle == '0) ? S_ACQ : S_SETTLE;
      S_SETTLE: if (r_cnt == r_settle - SETTLE_W'(1)) w_state_next = S_ACQ;
      S_ACQ:    if (adc_valid && (r_scnt == c_nsamp_m1)) w_state_next = S_EMIT;
      S_EMIT:   if (res_ready) w_state_next = w_last ? S_FIN : S_LOAD;
      S_FIN:    w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step    <= '0;
      r_npts_m1 <= '0;
      r_settle  <= '0;
      r_cnt     <= '0;
      r_scnt    <= '0;
      r_idx     <= '0;
      r_res_idx <= '0;
      r_dir     <= 1'b0;
      r_dac     <= '0;
      for (int c = 0; c < NCH; c++) r_pos[c] <= '0;
      for (int p = 0; p < NPROBE; p++) r_acc[p] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_step    <= cfg_step;
            r_npts_m1 <= (cfg_npts == 16'd0) ? 16'd0 : (cfg_npts - 16'd1);
            r_settle  <= cfg_settle;
            r_idx     <= '0;
            r_res_idx <= '0;
            r_dir     <= 1'b0;
            r_dac     <= cfg_start;
            for (int c = 0; c < NCH; c++)
              r_pos[c] <= {{(c_pw-DW){1'b0}}, cfg_start[c*DW +: DW]};
          end
        end
        S_LOAD: begin
          r_cnt  <= '0;
          r_scnt <= '0;
          for (int p = 0; p < NPROBE; p++) r_acc[p] <= '0;
        end
        S_SETTLE: r_cnt <= r_cnt + SETTLE_W'(1);
        S_ACQ: begin
          if (adc_valid) begin
            r_scnt <= r_scnt + c_sw'(1);
            for (int p = 0; p < NPROBE; p++)
              r_acc[p] <= r_acc[p] + c_accw'(adc_data[p*AW +: AW]);
          end
        end
        S_EMIT: begin
          if (w_xfer && !w_last) begin
            r_res_idx <= r_res_idx + 16'd1;
            r_idx     <= w_idx_next;
            r_dir     <= w_dir_next;
            r_dac     <= w_sat_next;
            for (int c = 0; c < NCH; c++) r_pos[c] <= w_pos_next[c];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE) && (r_state != S_FIN);
  assign done      = (r_state == S_FIN);
  assign dac_load  = (r_state == S_LOAD);
  assign dac_code  = r_dac;
  assign res_valid = (r_state == S_EMIT);
  assign res_index = r_res_idx;
`ifdef SWEEP_BIDIR_EN
  assign sweep_dir = r_dir;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bias_sweep_sequencer.sv
//------------------------------------------------------------------------------
// tb_bias_sweep_sequencer
//   Directed self-checking bench for bias_sweep_sequencer (default parameters).
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bias_sweep_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] cfg_start;
  logic [23:0] cfg_step;
  logic [15:0] cfg_npts;
  logic [7:0]  cfg_settle;
  logic        adc_valid;
  logic [23:0] adc_data;
  logic        res_ready;
  logic        busy;
  logic        done;
  logic [23:0] dac_code;
  logic        dac_load;
  logic        res_valid;
  logic [15:0] res_index;
  logic [27:0] res_data;
`ifdef SWEEP_BIDIR_EN
  logic        sweep_dir;
`endif

  int checks   = 0;
  int failures = 0;

  logic [23:0] dl_code [0:15];
  int          dl_cyc  [0:15];
  int          n_dl;
  logic [15:0] rs_idx  [0:15];
  logic [27:0] rs_data [0:15];
  logic        rs_dir  [0:15];
  int          n_res;
  int          done_cnt;
  int          timed_out;
  logic        busy_at_done;

  localparam logic [27:0] c_res_basic = {14'd28, 14'd200};

  bias_sweep_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_start  (cfg_start),
    .cfg_step   (cfg_step),
    .cfg_npts   (cfg_npts),
    .cfg_settle (cfg_settle),
    .busy       (busy),
    .done       (done),
    .dac_code   (dac_code),
    .dac_load   (dac_load),
    .adc_valid  (adc_valid),
    .adc_data   (adc_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_index  (res_index),
    .res_data   (res_data)
`ifdef SWEEP_BIDIR_EN
    ,
    .sweep_dir  (sweep_dir)
`endif
  );

  always #5 clk = ~clk;

  // Pulses start, then records loads/results once per negedge; i=0 is the LOAD cycle.
  task automatic run_sweep(input int budget);
    n_dl = 0; n_res = 0; done_cnt = 0; timed_out = 1; busy_at_done = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (dac_load && n_dl < 16) begin
        dl_code[n_dl] = dac_code; dl_cyc[n_dl] = i; n_dl++;
      end
      if (res_valid && res_ready && n_res < 16) begin
        rs_idx[n_res] = res_index; rs_data[n_res] = res_data;
`ifdef SWEEP_BIDIR_EN
        rs_dir[n_res] = sweep_dir;
`else
        rs_dir[n_res] = 1'b0;
`endif
        n_res++;
      end
      if (done) begin
        done_cnt++; busy_at_done = busy; timed_out = 0;
        break;
      end
    end
  endtask

  task automatic set_basic_cfg();
    cfg_start  = {12'd200, 12'd100};
    cfg_step   = {12'hFFB, 12'd10};
    cfg_npts   = 16'd3;
    cfg_settle = 8'd4;
    adc_valid  = 1'b1;
    adc_data   = {12'd7, 12'd50};
    res_ready  = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    set_basic_cfg();
    repeat (2) @(negedge clk);
    if ({busy, done, dac_load, res_valid} !== 4'b0) begin
      failures++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, dac_load, res_valid});
    end
    checks++;
    if (dac_code !== 24'd0) begin
      failures++; $display("FAIL reset_dac_code: got %0h expected 0", dac_code);
    end
    checks++;
    if ({res_index, res_data} !== 44'd0) begin
      failures++; $display("FAIL reset_res: got idx %0d data %0h expected 0", res_index, res_data);
    end
    checks++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [23:0] exp_code [0:2];
    exp_code[0] = {12'd200, 12'd100};
    exp_code[1] = {12'd195, 12'd110};
    exp_code[2] = {12'd190, 12'd120};
    set_basic_cfg();
    run_sweep(200);
    if (timed_out != 0 || n_dl != 3 || n_res != 3) begin
      failures++; $display("FAIL basic_counts: timeout %0d loads %0d results %0d expected 0 3 3", timed_out, n_dl, n_res);
    end
    checks++;
    for (int k = 0; k < 3; k++) begin
      if (dl_code[k] !== exp_code[k]) begin
        failures++; $display("FAIL basic_code%0d: got %0h expected %0h", k, dl_code[k], exp_code[k]);
      end
      checks++;
      if (rs_idx[k] !== 16'(k) || rs_data[k] !== c_res_basic) begin
        failures++; $display("FAIL basic_res%0d: got idx %0d data %0h expected idx %0d data %0h", k, rs_idx[k], rs_data[k], k, c_res_basic);
      end
      checks++;
    end
    if (dl_cyc[1] - dl_cyc[0] != 10 || dl_cyc[2] - dl_cyc[1] != 10) begin
      failures++; $display("FAIL basic_latency: got %0d,%0d expected 10,10", dl_cyc[1] - dl_cyc[0], dl_cyc[2] - dl_cyc[1]);
    end
    checks++;
    if (done_cnt != 1 || busy_at_done !== 1'b0) begin
      failures++; $display("FAIL basic_done: got done %0d busy %b expected 1 0", done_cnt, busy_at_done);
    end
    checks++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL basic_idle%0d: got done %b busy %b expected 0 0", k, done, busy);
      end
      checks++;
    end
    if (dac_code !== exp_code[2]) begin
      failures++; $display("FAIL basic_hold: got %0h expected %0h", dac_code, exp_code[2]);
    end
    checks++;
  endtask

  task automatic test_saturation();
    logic [23:0] exp_code [0:3];
    exp_code[0] = {12'd3, 12'd4090};
    exp_code[1] = {12'd1, 12'd4094};
    exp_code[2] = {12'd0, 12'd4095};
    exp_code[3] = {12'd0, 12'd4095};
    set_basic_cfg();
    cfg_start  = {12'd3, 12'd4090};
    cfg_step   = {12'hFFE, 12'd4};
    cfg_npts   = 16'd4;
    cfg_settle = 8'd0;
    run_sweep(200);
    if (timed_out != 0 || n_dl != 4) begin
      failures++; $display("FAIL sat_counts: timeout %0d loads %0d expected 0 4", timed_out, n_dl);
    end
    checks++;
    for (int k = 0; k < 4; k++) begin
      if (dl_code[k] !== exp_code[k]) begin
        failures++; $display("FAIL sat_code%0d: got %0h expected %0h", k, dl_code[k], exp_code[k]);
      end
      checks++;
    end
    if (dl_cyc[1] - dl_cyc[0] != 6) begin
      failures++; $display("FAIL sat_latency: got %0d expected 6", dl_cyc[1] - dl_cyc[0]);
    end
    checks++;
  endtask

  task automatic test_backpressure();
    int hold = 0;
    int stable = 1;
    int load_in_hold = 0;
    int done_seen = 0;
    logic [27:0] snap_d;
    set_basic_cfg();
    cfg_settle = 8'd2;
    n_dl = 0; n_res = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 3) begin
        start = 1'b1; cfg_start = {12'd5, 12'd5};
      end
      if (dac_load && n_dl < 16) begin
        dl_code[n_dl] = dac_code; dl_cyc[n_dl] = i; n_dl++;
        if (hold > 0 && hold < 10) load_in_hold = 1;
      end
      if (res_valid && res_index == 16'd1 && hold < 10) begin
        if (hold == 0) snap_d = res_data;
        else if (res_data !== snap_d) stable = 0;
        res_ready = 1'b0;
        hold++;
      end else begin
        res_ready = 1'b1;
      end
      if (res_valid && res_ready && n_res < 16) begin
        rs_idx[n_res] = res_index; rs_data[n_res] = res_data; n_res++;
      end
      if (done) begin
        done_seen = 1;
        break;
      end
    end
    res_ready = 1'b1;
    if (done_seen != 1 || hold != 10) begin
      failures++; $display("FAIL bp_hold: got done %0d hold %0d expected 1 10", done_seen, hold);
    end
    checks++;
    if (stable != 1 || snap_d !== c_res_basic) begin
      failures++; $display("FAIL bp_stable: got stable %0d data %0h expected 1 %0h", stable, snap_d, c_res_basic);
    end
    checks++;
    if (load_in_hold != 0 || n_dl != 3 || dl_cyc[2] - dl_cyc[1] != 18) begin
      failures++; $display("FAIL bp_load: got early %0d loads %0d gap %0d expected 0 3 18", load_in_hold, n_dl, dl_cyc[2] - dl_cyc[1]);
    end
    checks++;
    if (n_res != 3 || rs_idx[1] !== 16'd1 || rs_data[2] !== c_res_basic || dl_code[1] !== {12'd195, 12'd110}) begin
      failures++; $display("FAIL bp_results: got n %0d idx1 %0d data2 %0h code1 %0h expected 3 1 %0h c3006e", n_res, rs_idx[1], rs_data[2], dl_code[1], c_res_basic);
    end
    checks++;
  endtask

  task automatic test_gapped_adc();
    int got = 0;
    int n = 0;
    int e;
    int fin = 0;
    logic [27:0] got_d = '0;
    set_basic_cfg();
    cfg_start  = 24'd0;
    cfg_step   = 24'd0;
    cfg_npts   = 16'd1;
    cfg_settle = 8'd3;
    adc_valid  = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (res_valid) begin
        got = 1; got_d = res_data;
        break;
      end
      e = k + 1;
      if (e <= 4) begin
        adc_valid = 1'b1; adc_data = {12'd900, 12'd900};
      end else if (e >= 7 && (e - 7) % 3 == 0 && n < 4) begin
        n++;
        adc_valid = 1'b1; adc_data = {12'(n * 10), 12'(n)};
      end else begin
        adc_valid = 1'b0; adc_data = {12'd555, 12'd555};
      end
    end
    adc_valid = 1'b0;
    if (got != 1 || got_d !== {14'd100, 14'd10}) begin
      failures++; $display("FAIL gapped_sum: got seen %0d data %0h expected 1 %0h", got, got_d, {14'd100, 14'd10});
    end
    checks++;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) begin
        fin = 1;
        break;
      end
    end
    if (fin != 1) begin
      failures++; $display("FAIL gapped_done: got %0d expected 1", fin);
    end
    checks++;
    adc_valid = 1'b1;
  endtask

  task automatic test_reset_mid();
    int dseen = 0;
    set_basic_cfg();
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i <= 26; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) dseen++;
    end
    rst = 1'b1;
    #1;
    if ({busy, done, dac_load, res_valid} !== 4'b0 || dac_code !== 24'd0) begin
      failures++; $display("FAIL rstmid_out: got ctrl %b code %0h expected 0000 0", {busy, done, dac_load, res_valid}, dac_code);
    end
    checks++;
    if ({res_index, res_data} !== 44'd0 || dseen != 0) begin
      failures++; $display("FAIL rstmid_res: got idx %0d data %0h done %0d expected 0 0 0", res_index, res_data, dseen);
    end
    checks++;
    @(negedge clk);
    rst = 1'b0;
    cfg_npts = 16'd1;
    run_sweep(100);
    if (timed_out != 0 || n_res != 1 || dl_code[0] !== {12'd200, 12'd100} || rs_idx[0] !== 16'd0 || rs_data[0] !== c_res_basic) begin
      failures++; $display("FAIL rstmid_fresh: got timeout %0d n %0d code %0h idx %0d data %0h expected 0 1 c80064 0 %0h", timed_out, n_res, dl_code[0], rs_idx[0], rs_data[0], c_res_basic);
    end
    checks++;
  endtask

  task automatic test_npts_zero();
    set_basic_cfg();
    cfg_npts   = 16'd0;
    cfg_settle = 8'd1;
    run_sweep(100);
    if (timed_out != 0 || n_res != 1 || n_dl != 1 || done_cnt != 1) begin
      failures++; $display("FAIL npts0_count: got timeout %0d results %0d loads %0d done %0d expected 0 1 1 1", timed_out, n_res, n_dl, done_cnt);
    end
    checks++;
    if (rs_idx[0] !== 16'd0 || rs_data[0] !== c_res_basic) begin
      failures++; $display("FAIL npts0_res: got idx %0d data %0h expected 0 %0h", rs_idx[0], rs_data[0], c_res_basic);
    end
    checks++;
  endtask

`ifdef SWEEP_BIDIR_EN
  task automatic test_bidir();
    logic [23:0] exp_code [0:4];
    logic        exp_dir  [0:4];
    exp_code[0] = {12'd200, 12'd100}; exp_dir[0] = 1'b0;
    exp_code[1] = {12'd195, 12'd110}; exp_dir[1] = 1'b0;
    exp_code[2] = {12'd190, 12'd120}; exp_dir[2] = 1'b0;
    exp_code[3] = {12'd195, 12'd110}; exp_dir[3] = 1'b1;
    exp_code[4] = {12'd200, 12'd100}; exp_dir[4] = 1'b1;
    set_basic_cfg();
    run_sweep(300);
    if (timed_out != 0 || n_res != 5 || n_dl != 5) begin
      failures++; $display("FAIL bidir_counts: got timeout %0d results %0d loads %0d expected 0 5 5", timed_out, n_res, n_dl);
    end
    checks++;
    for (int k = 0; k < 5; k++) begin
      if (dl_code[k] !== exp_code[k] || rs_idx[k] !== 16'(k) || rs_dir[k] !== exp_dir[k]) begin
        failures++; $display("FAIL bidir_pt%0d: got code %0h idx %0d dir %b expected %0h %0d %b", k, dl_code[k], rs_idx[k], rs_dir[k], exp_code[k], k, exp_dir[k]);
      end
      checks++;
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef SWEEP_BIDIR_EN
    test_bidir();
`else
    test_basic();
    test_saturation();
    test_backpressure();
    test_gapped_adc();
    test_reset_mid();
`endif
    test_npts_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
